wb_fir_accel_slave: RTL and testbench

//  Wishbone classic slave FIR accelerator. Sits downstream of the compute-tile network adapter's WB master port.
//  NoC-delivered writes load coefficients and push samples; a sequential MAC engine filters them; reads pop results.
//  One tap per cycle: small area, deterministic latency.

---
 rtl/wb_fir_accel_slave_if.sv | 22 ++
 rtl/wb_fir_accel_slave.sv | 247 ++++++++++++++++++++++++
 tb/tb_wb_fir_accel_slave.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/wb_fir_accel_slave_if.sv
// Wishbone classic bundle between the compute-tile adapter (master) and the FIR accelerator (slave).
interface wb_fir_accel_slave_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface

// File: rtl/wb_fir_accel_slave.sv
// Wishbone FIR accelerator: sample/result FIFOs around a one-tap-per-cycle MAC engine.
// Optional FIR_ACCEL_IRQ_EN drives irq from IRQ_MASK and result availability.
//
// state    | meaning
// ST_IDLE  | waiting for ENABLE and a queued sample
// ST_SHIFT | pop sample into delay line, clear accumulator
// ST_MAC   | accumulate one coefficient*tap product per cycle
// ST_WRITE | saturate and push result, stall while output FIFO is full
module wb_fir_accel_slave #(
   parameter int TAPS       = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int SHIFT      = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   wb_fir_accel_slave_if.slave        wb,
   output logic                       irq
);
   localparam int TAP_W = $clog2(TAPS);
   localparam int ACC_W = 32 + TAP_W;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [5:0] WA_CTRL = 6'h00;
   localparam logic [5:0] WA_STAT = 6'h01;
   localparam logic [5:0] WA_DIN  = 6'h02;
   localparam logic [5:0] WA_DOUT = 6'h03;
   localparam logic [5:0] WA_COEF = 6'h10;
   localparam logic [6:0] TAPS_N  = 7'(TAPS);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MAC, ST_WRITE} state_t;

   state_t                   state_q, state_d;
   logic                     enable_q, enable_d;
   logic                     irq_mask_q, irq_mask_d;
   logic signed [15:0]       coef_q [TAPS];
   logic signed [15:0]       coef_d [TAPS];
   logic signed [15:0]       x_q [TAPS];
   logic signed [15:0]       x_d [TAPS];
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [TAP_W-1:0]         tap_q, tap_d;
   logic [PTR_W-1:0]         in_wr_q, in_wr_d, in_rd_q, in_rd_d;
   logic [PTR_W-1:0]         out_wr_q, out_wr_d, out_rd_q, out_rd_d;
   logic [CNT_W-1:0]         in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
   logic                     ack_q, ack_d, err_q, err_d, irq_q, irq_d;
   logic [31:0]              dat_q, dat_d;

   logic [15:0]              in_mem_q  [FIFO_DEPTH];
   logic [31:0]              out_mem_q [FIFO_DEPTH];

   logic                     req, clear, busy;
   logic                     in_push, in_pop, out_push, out_pop;
   logic                     in_full, in_empty, out_full, out_empty;
   logic [5:0]               widx, coef_idx;
   logic                     coef_hit;
   logic signed [31:0]       prod;
   logic signed [ACC_W-1:0]  acc_sh;
   logic [31:0]              y;
   logic                     unused_bits;

   assign req       = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
   assign widx      = wb.wb_adr_i[7:2];
   assign coef_idx  = widx - WA_COEF;
   assign coef_hit  = (widx >= WA_COEF) && ({1'b0, coef_idx} < TAPS_N);
   assign in_full   = (in_cnt_q == CNT_W'(FIFO_DEPTH));
   assign in_empty  = (in_cnt_q == '0);
   assign out_full  = (out_cnt_q == CNT_W'(FIFO_DEPTH));
   assign out_empty = (out_cnt_q == '0);
   assign busy      = (state_q != ST_IDLE);

   assign prod   = coef_q[tap_q] * x_q[tap_q];
   assign acc_sh = acc_q >>> SHIFT;

   // Clamp when the bits above bit 31 are not a pure sign extension.
   always_comb begin
      y = acc_sh[31:0];
      if (!((acc_sh[ACC_W-1:31] == '0) || (acc_sh[ACC_W-1:31] == '1))) begin
         y = acc_sh[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
   end

   always_comb begin
      state_d    = state_q;
      enable_d   = enable_q;
      irq_mask_d = irq_mask_q;
      coef_d     = coef_q;
      x_d        = x_q;
      acc_d      = acc_q;
      tap_d      = tap_q;
      in_wr_d    = in_wr_q;
      in_rd_d    = in_rd_q;
      out_wr_d   = out_wr_q;
      out_rd_d   = out_rd_q;
      in_cnt_d   = in_cnt_q;
      out_cnt_d  = out_cnt_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      dat_d      = 32'd0;
      in_push    = 1'b0;
      in_pop     = 1'b0;
      out_push   = 1'b0;
      out_pop    = 1'b0;
      clear      = 1'b0;

      if (req) begin
         if (wb.wb_we_i) begin
            if (widx == WA_CTRL) begin
               ack_d      = 1'b1;
               enable_d   = wb.wb_dat_i[0];
               clear      = wb.wb_dat_i[1];
               irq_mask_d = wb.wb_dat_i[2];
            end else if (widx == WA_DIN && !in_full) begin
               ack_d   = 1'b1;
               in_push = 1'b1;
            end else if (coef_hit) begin
               ack_d                            = 1'b1;
               coef_d[coef_idx[TAP_W-1:0]]      = wb.wb_dat_i[15:0];
            end else begin
               err_d = 1'b1;
            end
         end else begin
            if (widx == WA_CTRL) begin
               ack_d = 1'b1;
               dat_d = {29'd0, irq_mask_q, 1'b0, enable_q};
            end else if (widx == WA_STAT) begin
               ack_d = 1'b1;
               dat_d = {16'd0, 8'(out_cnt_q), 5'd0, busy, out_empty, in_full};
            end else if (widx == WA_DOUT && !out_empty) begin
               ack_d   = 1'b1;
               out_pop = 1'b1;
               dat_d   = out_mem_q[out_rd_q];
            end else if (coef_hit) begin
               ack_d = 1'b1;
               dat_d = {16'd0, coef_q[coef_idx[TAP_W-1:0]]};
            end else begin
               err_d = 1'b1;
            end
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (enable_q && !in_empty) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            in_pop = 1'b1;
            x_d[0] = in_mem_q[in_rd_q];
            for (int k = 1; k < TAPS; k++) x_d[k] = x_q[k-1];
            acc_d   = '0;
            tap_d   = '0;
            state_d = ST_MAC;
         end
         ST_MAC: begin
            acc_d = acc_q + {{TAP_W{prod[31]}}, prod};
            tap_d = tap_q + 1'b1;
            if (tap_q == TAP_W'(TAPS - 1)) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (!out_full) begin
               out_push = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (in_push)  in_wr_d  = in_wr_q + 1'b1;
      if (in_pop)   in_rd_d  = in_rd_q + 1'b1;
      if (out_push) out_wr_d = out_wr_q + 1'b1;
      if (out_pop)  out_rd_d = out_rd_q + 1'b1;
      in_cnt_d  = in_cnt_q + CNT_W'(in_push) - CNT_W'(in_pop);
      out_cnt_d = out_cnt_q + CNT_W'(out_push) - CNT_W'(out_pop);

      // CLEAR wins over any engine activity in the same cycle; coefficients survive.
      if (clear) begin
         state_d   = ST_IDLE;
         for (int k = 0; k < TAPS; k++) x_d[k] = '0;
         in_wr_d   = '0;
         in_rd_d   = '0;
         out_wr_d  = '0;
         out_rd_d  = '0;
         in_cnt_d  = '0;
         out_cnt_d = '0;
      end

`ifdef FIR_ACCEL_IRQ_EN
      irq_d = irq_mask_q & ~out_empty;
`else
      irq_d = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         enable_q   <= 1'b0;
         irq_mask_q <= 1'b0;
         for (int k = 0; k < TAPS; k++) begin
            coef_q[k] <= '0;
            x_q[k]    <= '0;
         end
         acc_q      <= '0;
         tap_q      <= '0;
         in_wr_q    <= '0;
         in_rd_q    <= '0;
         out_wr_q   <= '0;
         out_rd_q   <= '0;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         dat_q      <= 32'd0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         enable_q   <= enable_d;
         irq_mask_q <= irq_mask_d;
         coef_q     <= coef_d;
         x_q        <= x_d;
         acc_q      <= acc_d;
         tap_q      <= tap_d;
         in_wr_q    <= in_wr_d;
         in_rd_q    <= in_rd_d;
         out_wr_q   <= out_wr_d;
         out_rd_q   <= out_rd_d;
         in_cnt_q   <= in_cnt_d;
         out_cnt_q  <= out_cnt_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         dat_q      <= dat_d;
         irq_q      <= irq_d;
      end
   end

   // FIFO storage needs no reset: occupancy counters define validity.
   always_ff @(posedge clk) begin
      if (in_push)  in_mem_q[in_wr_q]   <= wb.wb_dat_i[15:0];
      if (out_push) out_mem_q[out_wr_q] <= y;
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_err_o = err_q;
   assign wb.wb_dat_o = dat_q;
   assign irq         = irq_q;

   assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[31:8], wb.wb_adr_i[1:0], wb.wb_dat_i[31:16]};
endmodule

// File: tb/tb_wb_fir_accel_slave.sv
// Directed bench for wb_fir_accel_slave; a SHIFT=4 twin shares the bus stimulus for scaling checks.
module tb_wb_fir_accel_slave;
   logic clk = 1'b0;
   logic rst_n;
   logic irq0, irq1;
   int   checks = 0;
   int   failures = 0;

   wb_fir_accel_slave_if bif0 ();
   wb_fir_accel_slave_if bif1 ();

   assign bif1.wb_adr_i = bif0.wb_adr_i;
   assign bif1.wb_dat_i = bif0.wb_dat_i;
   assign bif1.wb_sel_i = bif0.wb_sel_i;
   assign bif1.wb_we_i  = bif0.wb_we_i;
   assign bif1.wb_cyc_i = bif0.wb_cyc_i;
   assign bif1.wb_stb_i = bif0.wb_stb_i;

   wb_fir_accel_slave #(.TAPS(8), .FIFO_DEPTH(16), .SHIFT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .wb(bif0), .irq(irq0));
   wb_fir_accel_slave #(.TAPS(8), .FIFO_DEPTH(16), .SHIFT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .wb(bif1), .irq(irq1));

   always #5 clk = ~clk;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Returns ack/err as {ack,err}; both 0 means the access timed out.
   task automatic xfer(input logic we, input logic [7:0] a, input logic [31:0] d,
                       output logic [1:0] st, output logic [31:0] r0, output logic [31:0] r1);
      int n;
      @(posedge clk); #1;
      bif0.wb_adr_i = {24'd0, a};
      bif0.wb_dat_i = d;
      bif0.wb_we_i  = we;
      bif0.wb_cyc_i = 1'b1;
      bif0.wb_stb_i = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!(bif0.wb_ack_o | bif0.wb_err_o) && n < 8);
      st = {bif0.wb_ack_o, bif0.wb_err_o};
      r0 = bif0.wb_dat_o;
      r1 = bif1.wb_dat_o;
      bif0.wb_cyc_i = 1'b0;
      bif0.wb_stb_i = 1'b0;
      bif0.wb_we_i  = 1'b0;
   endtask

   task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d, input logic exp_err);
      logic [1:0] st;
      logic [31:0] r0, r1;
      xfer(1'b1, a, d, st, r0, r1);
      check32({tag, "_status"}, {30'd0, st}, exp_err ? 32'd1 : 32'd2);
   endtask

   task automatic rd(input string tag, input logic [7:0] a, input logic exp_err, input logic [31:0] exp0);
      logic [1:0] st;
      logic [31:0] r0, r1;
      xfer(1'b0, a, 32'd0, st, r0, r1);
      check32({tag, "_status"}, {30'd0, st}, exp_err ? 32'd1 : 32'd2);
      check32({tag, "_data"}, r0, exp_err ? 32'd0 : exp0);
   endtask

   initial begin
      logic [1:0]  st;
      logic [31:0] r0, r1;
      longint      v;

      rst_n = 1'b0;
      bif0.wb_adr_i = '0;
      bif0.wb_dat_i = '0;
      bif0.wb_sel_i = 4'hF;
      bif0.wb_we_i  = 1'b0;
      bif0.wb_cyc_i = 1'b0;
      bif0.wb_stb_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      @(posedge clk); #1;
      check32("rst_idle_bus", {29'd0, bif0.wb_ack_o, bif0.wb_err_o, irq0}, 32'd0);
      check32("rst_dat_o", bif0.wb_dat_o, 32'd0);
      rd("rst_stat", 8'h04, 1'b0, 32'h0000_0002);
      @(posedge clk); #1;
      check32("no_ack_after_access", {30'd0, bif0.wb_ack_o, bif0.wb_err_o}, 32'd0);
      rd("rst_coef3", 8'h4C, 1'b0, 32'd0);
      rd("rst_ctrl", 8'h00, 1'b0, 32'd0);
      rd("unmapped", 8'h20, 1'b1, 32'd0);
      wr("wr_stat_ro", 8'h04, 32'h1, 1'b1);
      rd("rd_din_wo", 8'h08, 1'b1, 32'd0);

      // Single tap passthrough
      wr("coef0", 8'h40, 32'd1, 1'b0);
      wr("en", 8'h00, 32'h1, 1'b0);
      wr("din5", 8'h08, 32'd5, 1'b0);
      wr("dinm3", 8'h08, 32'h0000_FFFD, 1'b0);
      repeat (30) @(posedge clk);
      rd("dout5", 8'h0C, 1'b0, 32'h0000_0005);
      rd("doutm3", 8'h0C, 1'b0, 32'hFFFF_FFFD);
      rd("dout_empty", 8'h0C, 1'b1, 32'd0);

      // Moving sum with all coefficients 1
      wr("clr_en", 8'h00, 32'h3, 1'b0);
      for (int k = 0; k < 8; k++) wr($sformatf("coef1_%0d", k), 8'(8'h40 + 4 * k), 32'd1, 1'b0);
      rd("coef7_rb", 8'h5C, 1'b0, 32'd1);
      for (int k = 0; k < 8; k++) wr($sformatf("din100_%0d", k), 8'h08, 32'd100, 1'b0);
      repeat (120) @(posedge clk);
      for (int k = 1; k <= 8; k++) rd($sformatf("sum_%0d", k), 8'h0C, 1'b0, 32'(100 * k));
      wr("din100_9", 8'h08, 32'd100, 1'b0);
      repeat (20) @(posedge clk);
      rd("sum_9", 8'h0C, 1'b0, 32'd800);

      // Input FIFO fill with engine disabled
      wr("clr_dis", 8'h00, 32'h2, 1'b0);
      for (int k = 0; k < 16; k++) wr($sformatf("fill_%0d", k), 8'h08, 32'd1, 1'b0);
      wr("fill_over", 8'h08, 32'd1, 1'b1);
      rd("stat_full", 8'h04, 1'b0, 32'h0000_0003);
      wr("en2", 8'h00, 32'h1, 1'b0);
      repeat (220) @(posedge clk);
      rd("stat_out16", 8'h04, 1'b0, 32'h0000_1000);
      for (int j = 1; j <= 16; j++) rd($sformatf("drain_%0d", j), 8'h0C, 1'b0, (j < 8) ? 32'(j) : 32'd8);
      rd("stat_drained", 8'h04, 1'b0, 32'h0000_0002);

      // Saturation (SHIFT=0) and scaled result (SHIFT=4 twin)
      wr("clr_en3", 8'h00, 32'h3, 1'b0);
      for (int k = 0; k < 8; k++) wr($sformatf("coefmax_%0d", k), 8'(8'h40 + 4 * k), 32'h7FFF, 1'b0);
      for (int k = 0; k < 8; k++) wr($sformatf("dinmax_%0d", k), 8'h08, 32'h7FFF, 1'b0);
      repeat (120) @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
         v = longint'(k) * 64'h3FFF_0001;
         xfer(1'b0, 8'h0C, 32'd0, st, r0, r1);
         check32($sformatf("sat_status_%0d", k), {30'd0, st}, 32'd2);
         check32($sformatf("sat_s0_%0d", k), r0, (v > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : v[31:0]);
         check32($sformatf("sat_s4_%0d", k), r1, 32'(v >> 4));
      end

      // CLEAR while the engine is mid-block
      wr("en_mask", 8'h00, 32'h5, 1'b0);
      rd("ctrl_rb", 8'h00, 1'b0, 32'h0000_0005);
      wr("din_mid", 8'h08, 32'd1, 1'b0);
      rd("stat_busy", 8'h04, 1'b0, 32'h0000_0006);
      wr("clr_mid", 8'h00, 32'h7, 1'b0);
      rd("stat_after_clr", 8'h04, 1'b0, 32'h0000_0002);
      repeat (20) @(posedge clk);
      rd("stat_no_stale", 8'h04, 1'b0, 32'h0000_0002);
      rd("dout_no_stale", 8'h0C, 1'b1, 32'd0);
      check32("irq_low", {31'd0, irq0}, 32'd0);
      rd("ctrl_after_clr", 8'h00, 1'b0, 32'h0000_0005);
      rd("coef0_kept", 8'h40, 1'b0, 32'h0000_7FFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
